mem_port_arbiter: RTL and testbench

//  Shares the single Memory33 port between two requesters: port 0 = Pipeline, port 1 = loader/DMA.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_arb_rdtrack.sv | 37 +++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the Memory33 port arbiter: port ids, lock owner encoding
// and the request bundle steered onto the memory port.
package rudolv_mem_pkg;

  localparam int unsigned ADDR_W_MAX = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_e;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_CPU  = 2'd1,
    LOCK_DMA  = 2'd2
  } lock_owner_e;

  typedef struct packed {
    logic                  write;
    logic [3:0]            wmask;
    logic [31:0]           wdata;
    logic                  wgrubby;
    logic [ADDR_W_MAX-1:0] addr;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_rdtrack.sv
// Tag pipeline for granted reads: each stage carries {valid, port id} so the
// returning memory word can be routed to the requester that issued it.
module mem_arb_rdtrack
  import rudolv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_push_valid,
  input  port_id_e i_push_port,
  output logic     o_tail_valid,
  output port_id_e o_tail_port
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_port;

  // Shift tags one stage per cycle; reset drops every pending read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_port  <= '0;
    end else begin
      r_valid[0] <= i_push_valid;
      r_port[0]  <= i_push_port;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_port[i]  <= r_port[i-1];
      end
    end
  end

  assign o_tail_valid = r_valid[DEPTH-1];
  assign o_tail_port  = port_id_e'(r_port[DEPTH-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single Memory33 port between the pipeline (port 0) and the
// loader/DMA (port 1): one grant per cycle, read data routed back by tag.
module mem_port_arbiter
  import rudolv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 8,
  parameter int unsigned ROUND_ROBIN  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_valid,
  input  logic                  p0_lock,
  input  logic                  p0_write,
  input  logic [3:0]            p0_wmask,
  input  logic [31:0]           p0_wdata,
  input  logic                  p0_wgrubby,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ready,
  output logic                  p0_rvalid,
  output logic [31:0]           p0_rdata,
  output logic                  p0_rgrubby,
  input  logic                  p1_valid,
  input  logic                  p1_lock,
  input  logic                  p1_write,
  input  logic [3:0]            p1_wmask,
  input  logic [31:0]           p1_wdata,
  input  logic                  p1_wgrubby,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_ready,
  output logic                  p1_rvalid,
  output logic [31:0]           p1_rdata,
  output logic                  p1_rgrubby,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic                  mem_wgrubby,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rgrubby,
  output logic [31:0]           conflicts
);

  lock_owner_e r_lock;
  port_id_e    r_rr_ptr;
  logic [7:0]  r_wait;
  logic [31:0] r_conflicts;

  logic        w_conflict;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_wait_full;
  mem_req_t    w_req0;
  mem_req_t    w_req1;
  mem_req_t    w_req;
  logic        w_rd_push;
  port_id_e    w_rd_port;
  logic        w_tail_valid;
  port_id_e    w_tail_port;

  assign w_conflict  = p0_valid & p1_valid;
  assign w_wait_full = (r_wait == 8'(MAX_WAIT));

  // Grant priority: lock owner, then starved port 1, then fixed/alternating policy.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_lock == LOCK_CPU && p0_valid) begin
      w_gnt0 = 1'b1;
    end else if (r_lock == LOCK_DMA && p1_valid) begin
      w_gnt1 = 1'b1;
    end else if (p1_valid && w_wait_full) begin
      w_gnt1 = 1'b1;
    end else if (ROUND_ROBIN == 0) begin
      w_gnt0 = p0_valid;
      w_gnt1 = ~p0_valid & p1_valid;
    end else if (w_conflict) begin
      w_gnt0 = (r_rr_ptr == PORT_CPU);
      w_gnt1 = (r_rr_ptr == PORT_DMA);
    end else begin
      w_gnt0 = p0_valid;
      w_gnt1 = p1_valid;
    end
  end

  // Steer the winner's request fields onto the memory port, zero when idle.
  always_comb begin
    w_req0 = '{write: p0_write, wmask: p0_wmask, wdata: p0_wdata,
               wgrubby: p0_wgrubby, addr: ADDR_W_MAX'(p0_addr)};
    w_req1 = '{write: p1_write, wmask: p1_wmask, wdata: p1_wdata,
               wgrubby: p1_wgrubby, addr: ADDR_W_MAX'(p1_addr)};
    w_req  = '0;
    if (w_gnt1)      w_req = w_req1;
    else if (w_gnt0) w_req = w_req0;
  end

  assign p0_ready    = w_gnt0;
  assign p1_ready    = w_gnt1;
  assign mem_valid   = p0_valid | p1_valid;
  assign mem_write   = w_req.write;
  assign mem_wmask   = w_req.wmask;
  assign mem_wdata   = w_req.wdata;
  assign mem_wgrubby = w_req.wgrubby;
  assign mem_addr    = ADDR_WIDTH'(w_req.addr);

  // Lock owner: a granted request decides the new owner; an owner that
  // drops valid without being granted releases the lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lock <= LOCK_NONE;
    end else if (w_gnt0) begin
      r_lock <= p0_lock ? LOCK_CPU : LOCK_NONE;
    end else if (w_gnt1) begin
      r_lock <= p1_lock ? LOCK_DMA : LOCK_NONE;
    end else if ((r_lock == LOCK_CPU && !p0_valid) ||
                 (r_lock == LOCK_DMA && !p1_valid)) begin
      r_lock <= LOCK_NONE;
    end
  end

  // Port 1 refusal counter, clamped at MAX_WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait <= '0;
    end else if (w_gnt1) begin
      r_wait <= '0;
    end else if (p1_valid && !w_wait_full) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  // Alternation pointer moves to the loser of each conflict cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= PORT_CPU;
    end else if (w_conflict) begin
      r_rr_ptr <= w_gnt0 ? PORT_DMA : PORT_CPU;
    end
  end

  // Conflict cycle counter for performance CSRs, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_conflicts <= '0;
    end else if (w_conflict) begin
      r_conflicts <= r_conflicts + 32'd1;
    end
  end

  assign conflicts = r_conflicts;

  assign w_rd_push = (w_gnt0 & ~p0_write) | (w_gnt1 & ~p1_write);
  assign w_rd_port = w_gnt1 ? PORT_DMA : PORT_CPU;

  mem_arb_rdtrack #(
    .DEPTH(READ_LATENCY)
  ) u_rdtrack (
    .clk         (clk),
    .rstn        (rstn),
    .i_push_valid(w_rd_push),
    .i_push_port (w_rd_port),
    .o_tail_valid(w_tail_valid),
    .o_tail_port (w_tail_port)
  );

  assign p0_rvalid  = w_tail_valid & (w_tail_port == PORT_CPU);
  assign p1_rvalid  = w_tail_valid & (w_tail_port == PORT_DMA);
  assign p0_rdata   = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata   = p1_rvalid ? mem_rdata : '0;
  assign p0_rgrubby = p0_rvalid & mem_rgrubby;
  assign p1_rgrubby = p1_rvalid & mem_rgrubby;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (fixed priority, latency 1)
// and instance B (alternation, latency 3) with a scoreboard of read returns.
module tb_mem_port_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn[2];
  logic        p0_valid[2], p0_lock[2], p0_write[2], p0_wgrubby[2];
  logic [3:0]  p0_wmask[2];
  logic [31:0] p0_wdata[2], p0_addr[2];
  logic        p1_valid[2], p1_lock[2], p1_write[2], p1_wgrubby[2];
  logic [3:0]  p1_wmask[2];
  logic [31:0] p1_wdata[2], p1_addr[2];
  logic        p0_ready[2], p0_rvalid[2], p0_rgrubby[2];
  logic [31:0] p0_rdata[2];
  logic        p1_ready[2], p1_rvalid[2], p1_rgrubby[2];
  logic [31:0] p1_rdata[2];
  logic        mem_valid[2], mem_write[2], mem_wgrubby[2], mem_rgrubby[2];
  logic [3:0]  mem_wmask[2];
  logic [31:0] mem_wdata[2], mem_addr[2], mem_rdata[2], conflicts[2];

  typedef struct {
    int          inst;
    int unsigned due;
    logic        port;
    logic [31:0] data;
    logic        grubby;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        sb_off = 1'b0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .READ_LATENCY(LAT_A), .MAX_WAIT(8), .ROUND_ROBIN(0)
  ) dut_a (
    .clk(clk), .rstn(rstn[0]),
    .p0_valid(p0_valid[0]), .p0_lock(p0_lock[0]), .p0_write(p0_write[0]),
    .p0_wmask(p0_wmask[0]), .p0_wdata(p0_wdata[0]), .p0_wgrubby(p0_wgrubby[0]),
    .p0_addr(p0_addr[0]), .p0_ready(p0_ready[0]), .p0_rvalid(p0_rvalid[0]),
    .p0_rdata(p0_rdata[0]), .p0_rgrubby(p0_rgrubby[0]),
    .p1_valid(p1_valid[0]), .p1_lock(p1_lock[0]), .p1_write(p1_write[0]),
    .p1_wmask(p1_wmask[0]), .p1_wdata(p1_wdata[0]), .p1_wgrubby(p1_wgrubby[0]),
    .p1_addr(p1_addr[0]), .p1_ready(p1_ready[0]), .p1_rvalid(p1_rvalid[0]),
    .p1_rdata(p1_rdata[0]), .p1_rgrubby(p1_rgrubby[0]),
    .mem_valid(mem_valid[0]), .mem_write(mem_write[0]), .mem_wmask(mem_wmask[0]),
    .mem_wdata(mem_wdata[0]), .mem_wgrubby(mem_wgrubby[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .mem_rgrubby(mem_rgrubby[0]), .conflicts(conflicts[0])
  );

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .READ_LATENCY(LAT_B), .MAX_WAIT(8), .ROUND_ROBIN(1)
  ) dut_b (
    .clk(clk), .rstn(rstn[1]),
    .p0_valid(p0_valid[1]), .p0_lock(p0_lock[1]), .p0_write(p0_write[1]),
    .p0_wmask(p0_wmask[1]), .p0_wdata(p0_wdata[1]), .p0_wgrubby(p0_wgrubby[1]),
    .p0_addr(p0_addr[1]), .p0_ready(p0_ready[1]), .p0_rvalid(p0_rvalid[1]),
    .p0_rdata(p0_rdata[1]), .p0_rgrubby(p0_rgrubby[1]),
    .p1_valid(p1_valid[1]), .p1_lock(p1_lock[1]), .p1_write(p1_write[1]),
    .p1_wmask(p1_wmask[1]), .p1_wdata(p1_wdata[1]), .p1_wgrubby(p1_wgrubby[1]),
    .p1_addr(p1_addr[1]), .p1_ready(p1_ready[1]), .p1_rvalid(p1_rvalid[1]),
    .p1_rdata(p1_rdata[1]), .p1_rgrubby(p1_rgrubby[1]),
    .mem_valid(mem_valid[1]), .mem_write(mem_write[1]), .mem_wmask(mem_wmask[1]),
    .mem_wdata(mem_wdata[1]), .mem_wgrubby(mem_wgrubby[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .mem_rgrubby(mem_rgrubby[1]), .conflicts(conflicts[1])
  );

  // Memory33 model: word content is a fixed function of the address,
  // returned LAT cycles after the address was presented.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic int unsigned lat(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  logic [31:0] apipe[2][4];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 3; s > 0; s--) apipe[i][s] <= apipe[i][s-1];
      apipe[i][0] <= mem_addr[i];
    end
  end

  always_comb begin
    mem_rdata[0]   = mem_word(apipe[0][LAT_A-1]);
    mem_rgrubby[0] = apipe[0][LAT_A-1][2];
    mem_rdata[1]   = mem_word(apipe[1][LAT_B-1]);
    mem_rgrubby[1] = apipe[1][LAT_B-1][2];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check grants/memory steering against the expected
  // winners, record expected reads, check read returns, then clock.
  task automatic step(input logic [1:0] ea, input logic [1:0] eb);
    logic [1:0]  eg;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_wr, e_wg;
    logic [67:0] e_ret;
    int          k;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      eg = (i == 0) ? ea : eb;
      {e_addr, e_wdata, e_wmask, e_wr, e_wg} = '0;
      if (eg[0]) begin
        e_addr = p1_addr[i]; e_wdata = p1_wdata[i]; e_wmask = p1_wmask[i];
        e_wr = p1_write[i]; e_wg = p1_wgrubby[i];
      end else if (eg[1]) begin
        e_addr = p0_addr[i]; e_wdata = p0_wdata[i]; e_wmask = p0_wmask[i];
        e_wr = p0_write[i]; e_wg = p0_wgrubby[i];
      end
      check((i == 0) ? "grant_a" : "grant_b",
            {p0_ready[i], p1_ready[i], mem_valid[i], mem_write[i], mem_wmask[i],
             mem_wdata[i], mem_wgrubby[i], mem_addr[i]},
            {eg, p0_valid[i] | p1_valid[i], e_wr, e_wmask, e_wdata, e_wg, e_addr});
      if (!sb_off && eg[1] && !p0_write[i])
        sbq.push_back('{inst: i, due: cyc + lat(i), port: 1'b0,
                        data: mem_word(p0_addr[i]), grubby: p0_addr[i][2]});
      if (!sb_off && eg[0] && !p1_write[i])
        sbq.push_back('{inst: i, due: cyc + lat(i), port: 1'b1,
                        data: mem_word(p1_addr[i]), grubby: p1_addr[i][2]});
      e_ret = '0;
      k = -1;
      for (int j = 0; j < sbq.size(); j++) begin
        if (sbq[j].inst == i) begin
          k = j;
          break;
        end
      end
      if (k >= 0 && sbq[k].due <= cyc) begin
        if (sbq[k].port == 1'b0) e_ret[67:34] = {1'b1, sbq[k].grubby, sbq[k].data};
        else                     e_ret[33:0]  = {1'b1, sbq[k].grubby, sbq[k].data};
        sbq.delete(k);
      end
      check((i == 0) ? "rdret_a" : "rdret_b",
            {p0_rvalid[i], p0_rgrubby[i], p0_rdata[i], p1_rvalid[i], p1_rgrubby[i], p1_rdata[i]},
            e_ret);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0;
      p0_valid[i] = 0; p0_lock[i] = 0; p0_write[i] = 0; p0_wmask[i] = '0;
      p0_wdata[i] = '0; p0_wgrubby[i] = 0; p0_addr[i] = '0;
      p1_valid[i] = 0; p1_lock[i] = 0; p1_write[i] = 0; p1_wmask[i] = '0;
      p1_wdata[i] = '0; p1_wgrubby[i] = 0; p1_addr[i] = '0;
    end
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    check("reset_conflicts_a", conflicts[0], 32'd0);
    check("reset_conflicts_b", conflicts[1], 32'd0);

    // Lone p0 read: granted same cycle, data one cycle later.
    p0_valid[0] = 1; p0_addr[0] = 32'h100;
    step(2'b10, 2'b00);
    p0_valid[0] = 0;
    step(2'b00, 2'b00);

    // Starvation guard: p1 locked write refused 8 times, forced on the 9th.
    p0_valid[0] = 1; p0_addr[0] = 32'h300;
    p1_valid[0] = 1; p1_write[0] = 1; p1_lock[0] = 1; p1_addr[0] = 32'h200;
    p1_wdata[0] = 32'hCAFE_F00D; p1_wmask[0] = 4'hF; p1_wgrubby[0] = 1;
    for (int n = 0; n < 8; n++) begin
      step(2'b10, 2'b00);
      p0_addr[0] = p0_addr[0] + 32'd4;
    end
    check("wait_at_max", dut_a.r_wait, 8'd8);
    step(2'b01, 2'b00);
    check("wait_cleared", dut_a.r_wait, 8'd0);
    // Locked pair: p1 read follows its write despite p0 valid.
    p1_write[0] = 0; p1_lock[0] = 0; p1_wgrubby[0] = 0; p1_wmask[0] = '0; p1_wdata[0] = '0;
    step(2'b01, 2'b00);
    check("conflicts_a_10", conflicts[0], 32'd10);
    p1_valid[0] = 0;
    step(2'b10, 2'b00);
    p0_valid[0] = 0;
    step(2'b00, 2'b00);

    // p0 lock outranks the starvation guard; wait counter clamps at 8.
    p0_valid[0] = 1; p0_lock[0] = 1; p0_addr[0] = 32'h500;
    p1_valid[0] = 1; p1_addr[0] = 32'h604;
    for (int n = 0; n < 10; n++) begin
      step(2'b10, 2'b00);
      p0_addr[0] = p0_addr[0] + 32'd4;
    end
    check("wait_clamped", dut_a.r_wait, 8'd8);
    p0_lock[0] = 0;
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    p0_valid[0] = 0; p1_valid[0] = 0;
    step(2'b00, 2'b00);

    // Reset right after a granted read: its data must never appear.
    p0_valid[0] = 1; p0_addr[0] = 32'h180;
    sb_off = 1;
    step(2'b10, 2'b00);
    sb_off = 0;
    rstn[0] = 0; p0_valid[0] = 0;
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    check("rst_conflicts", conflicts[0], 32'd0);
    check("rst_wait", dut_a.r_wait, 8'd0);
    rstn[0] = 1;
    for (int n = 0; n < 3; n++) step(2'b00, 2'b00);

    // Conflict counter wrap from a preset near the top.
    force dut_a.r_conflicts = 32'hFFFF_FFFE;
    #1;
    release dut_a.r_conflicts;
    check("preset", conflicts[0], 32'hFFFF_FFFE);
    p0_valid[0] = 1; p0_addr[0] = 32'h40;
    p1_valid[0] = 1; p1_addr[0] = 32'h44;
    step(2'b10, 2'b00);
    check("conf_max", conflicts[0], 32'hFFFF_FFFF);
    p0_addr[0] = 32'h48;
    step(2'b10, 2'b00);
    check("conf_wrap", conflicts[0], 32'd0);
    p0_valid[0] = 0;
    step(2'b01, 2'b00);
    p1_valid[0] = 0;
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    check("conf_hold", conflicts[0], 32'd0);

    // Instance B: alternation on conflict, reads return after 3 cycles.
    p0_valid[1] = 1; p0_addr[1] = 32'h10;
    p1_valid[1] = 1; p1_addr[1] = 32'h14;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) begin
        step(2'b00, 2'b10);
        p0_addr[1] = p0_addr[1] + 32'h20;
      end else begin
        step(2'b00, 2'b01);
        p1_addr[1] = p1_addr[1] + 32'h20;
      end
    end
    p0_valid[1] = 0; p1_valid[1] = 0;
    check("conflicts_b_6", conflicts[1], 32'd6);
    for (int n = 0; n < 4; n++) step(2'b00, 2'b00);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
